// File: rtl/rll_pkg.sv
// Shared types and sizing helpers for the RLL key loader.
package rll_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_FETCH,
    LD_GAP,
    LD_CHECK,
    LD_DONE,
    LD_ERR
  } rll_ld_state_t;

  function automatic int unsigned n_chunks(input int unsigned key_w, input int unsigned chunk_w);
    return key_w / chunk_w;
  endfunction

  // Address space covers every key chunk plus the trailing check word.
  function automatic int unsigned addr_w(input int unsigned key_w, input int unsigned chunk_w);
    return $clog2(key_w / chunk_w + 1);
  endfunction

endpackage

// File: rtl/rll_key_fetch.sv
// Key-store request/ack handshake with per-request timeout counter.
module rll_key_fetch #(
  parameter int unsigned CHUNK_W = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_start,
  output logic               key_req,
  input  logic               key_ack,
  input  logic [CHUNK_W-1:0] key_data,
  output logic               chunk_stb,
  output logic [CHUNK_W-1:0] chunk_data,
  output logic               timeout
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // An ack landing on the final allowed cycle takes priority over the timeout.
  assign chunk_stb  = key_req & key_ack;
  assign chunk_data = key_data;
  assign timeout    = key_req & ~key_ack & (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_req <= 1'b0;
      tmo_cnt <= '0;
    end else if (req_start) begin
      key_req <= 1'b1;
      tmo_cnt <= '0;
    end else if (chunk_stb || timeout) begin
      key_req <= 1'b0;
      tmo_cnt <= '0;
    end else if (key_req) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rll_key_loader.sv
// Fetches, verifies and commits the unlock key for one logic-locked core,
// gating the core outputs until a verified key is active.
module rll_key_loader
  import rll_pkg::*;
#(
  parameter int unsigned      KEY_W    = 16,
  parameter int unsigned      CHUNK_W  = 8,
  parameter int unsigned      OUT_W    = 32,
  parameter int unsigned      TIMEOUT  = 255,
  parameter logic [OUT_W-1:0] GATE_VAL = '0,
  localparam int unsigned     N_CHUNKS = n_chunks(KEY_W, CHUNK_W),
  localparam int unsigned     ADDR_W   = addr_w(KEY_W, CHUNK_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              key_req,
  output logic [ADDR_W-1:0] key_addr,
  input  logic              key_ack,
  input  logic [CHUNK_W-1:0] key_data,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  output logic              busy,
  output logic              err,
  input  logic [OUT_W-1:0]  core_in,
  output logic [OUT_W-1:0]  core_out
);

  rll_ld_state_t      state;
  logic [KEY_W-1:0]   shadow;
  logic [CHUNK_W-1:0] xor_acc;
  logic [CHUNK_W-1:0] check_word;
  logic               idle_like;
  logic               req_start;
  logic               chunk_stb;
  logic [CHUNK_W-1:0] chunk_data;
  logic               timeout;

  assign idle_like = (state == LD_IDLE) || (state == LD_DONE) || (state == LD_ERR);
  assign req_start = (state == LD_GAP) || (idle_like && start);

  rll_key_fetch #(
    .CHUNK_W (CHUNK_W),
    .TIMEOUT (TIMEOUT)
  ) u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_start  (req_start),
    .key_req    (key_req),
    .key_ack    (key_ack),
    .key_data   (key_data),
    .chunk_stb  (chunk_stb),
    .chunk_data (chunk_data),
    .timeout    (timeout)
  );

  // key_out is only ever zero or a verified key; chunks accumulate in shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LD_IDLE;
      key_addr   <= '0;
      key_out    <= '0;
      key_valid  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      shadow     <= '0;
      xor_acc    <= '0;
      check_word <= '0;
    end else begin
      unique case (state)
        LD_IDLE, LD_DONE, LD_ERR: begin
          if (start) begin
            state     <= LD_FETCH;
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
            key_addr  <= '0;
            xor_acc   <= '0;
            busy      <= 1'b1;
          end
        end
        LD_FETCH: begin
          if (chunk_stb) begin
            if (key_addr == ADDR_W'(N_CHUNKS)) begin
              check_word <= chunk_data;
              state      <= LD_CHECK;
            end else begin
              for (int unsigned i = 0; i < N_CHUNKS; i++) begin
                if (key_addr == ADDR_W'(i)) shadow[i*CHUNK_W +: CHUNK_W] <= chunk_data;
              end
              xor_acc  <= xor_acc ^ chunk_data;
              key_addr <= key_addr + 1'b1;
              state    <= LD_GAP;
            end
          end else if (timeout) begin
            state <= LD_ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end
        end
        LD_GAP: begin
          state <= LD_FETCH;
        end
        LD_CHECK: begin
          busy <= 1'b0;
          if (check_word == xor_acc) begin
            key_out   <= shadow;
            key_valid <= 1'b1;
            state     <= LD_DONE;
          end else begin
            err   <= 1'b1;
            state <= LD_ERR;
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

  assign core_out = key_valid ? core_in : GATE_VAL;

endmodule
